// File: rtl/risc_v_32_i_pkg.sv
// ---------------------------------------------------------------------------
// risc_v_32_i_pkg
// Shared RV32I definitions:
//   imm_select_e   - instruction format selector (UNKNOWN means R-format)
//   IMM*_MIN/MAX   - signed ranges representable by the I/S, B and J
//                    immediate fields
//   instr_fields_t - decoded instruction fields, used as the S1 register
//                    of instr_encoder and as the input of instr_pack
// ---------------------------------------------------------------------------
package risc_v_32_i_pkg;

    typedef enum logic [2:0] {
        IMM_I_TYPE       = 3'd0,
        IMM_S_TYPE       = 3'd1,
        IMM_B_TYPE       = 3'd2,
        IMM_U_TYPE       = 3'd3,
        IMM_J_TYPE       = 3'd4,
        IMM_UNKNOWN_TYPE = 3'd5
    } imm_select_e;

    // 12-bit immediate (I and S formats)
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    // 13-bit branch offset, bit 0 implied zero
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    // 21-bit jump offset, bit 0 implied zero
    localparam int IMM21_MIN = -1048576;
    localparam int IMM21_MAX = 1048574;

    typedef struct packed {
        imm_select_e imm_sel;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/instr_pack.sv
// ---------------------------------------------------------------------------
// instr_pack
// Purely combinational RV32I field packer. Places register, funct and
// immediate fields into a 32-bit instruction word according to the format
// in fields.imm_sel. Immediates are truncated to the bits the format can
// carry; any unrecognised selector packs as R-format.
// Ports:
//   fields - decoded instruction fields (instr_fields_t)
//   instr  - packed 32-bit instruction word
// ---------------------------------------------------------------------------
module instr_pack
    import risc_v_32_i_pkg::*;
(
    input  instr_fields_t fields,
    output logic [31:0]   instr
);

    always_comb begin
        instr = '0;
        case (fields.imm_sel)
            IMM_I_TYPE: instr = {fields.imm[11:0], fields.rs1, fields.funct3,
                                 fields.rd, fields.opcode};
            IMM_S_TYPE: instr = {fields.imm[11:5], fields.rs2, fields.rs1,
                                 fields.funct3, fields.imm[4:0], fields.opcode};
            // B and J scramble the offset bits so that the sign bit always
            // sits in instr[31], matching the core's sign extender.
            IMM_B_TYPE: instr = {fields.imm[12], fields.imm[10:5], fields.rs2,
                                 fields.rs1, fields.funct3, fields.imm[4:1],
                                 fields.imm[11], fields.opcode};
            IMM_U_TYPE: instr = {fields.imm[31:12], fields.rd, fields.opcode};
            IMM_J_TYPE: instr = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                                 fields.imm[19:12], fields.rd, fields.opcode};
            default:    instr = {fields.funct7, fields.rs2, fields.rs1,
                                 fields.funct3, fields.rd, fields.opcode};
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Streaming RV32I instruction encoder, two-stage valid/ready pipeline.
//   S1 registers the decoded input fields (plus the range error),
//   S2 registers the packed word (plus the error flag).
// Optional macro IMM_RANGE_CHECK_EN: when defined, immediates that the
// selected format cannot represent raise err_o and are counted in the
// saturating err_cnt_o. When undefined, err_o/err_cnt_o are tied to zero and
// no range logic exists. Packing and handshake are identical in both builds.
// Ports:
//   clk_i, rst_n_i            - clock, asynchronous active-low reset
//   valid_i, ready_o          - input handshake
//   imm_sel_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i
//                             - decoded instruction fields
//   valid_o, ready_i          - output handshake
//   instr_o                   - encoded instruction
//   err_o                     - immediate not representable (with valid_o)
//   err_cnt_o                 - saturating count of emitted error beats
// ---------------------------------------------------------------------------
module instr_encoder
    import risc_v_32_i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  imm_select_e     imm_sel_i,
    input  logic [6:0]      opcode_i,
    input  logic [4:0]      rd_i,
    input  logic [4:0]      rs1_i,
    input  logic [4:0]      rs2_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] imm_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [31:0]     instr_o,
    output logic            err_o,
    output logic [7:0]      err_cnt_o
);

    logic          s1_valid;
    instr_fields_t s1_fields;
    logic          s2_valid;
    logic [31:0]   s2_instr;
    instr_fields_t in_fields;
    logic [31:0]   packed_word;
    logic          en1;
    logic          en2;

    // A stage may load when it is empty or when the stage after it frees up
    // in the same cycle; this keeps full rate with ready_i held high.
    assign en2     = !s2_valid || ready_i;
    assign en1     = !s1_valid || en2;
    assign ready_o = en1;

    always_comb begin
        in_fields.imm_sel = imm_sel_i;
        in_fields.opcode  = opcode_i;
        in_fields.rd      = rd_i;
        in_fields.rs1     = rs1_i;
        in_fields.rs2     = rs2_i;
        in_fields.funct3  = funct3_i;
        in_fields.funct7  = funct7_i;
        in_fields.imm     = imm_i;
    end

    // S1: capture the fields of an accepted beat. Fields are only reloaded on
    // a real beat so that idle inputs do not toggle the register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid  <= 1'b0;
            s1_fields <= '0;
        end else if (en1) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_fields <= in_fields;
            end
        end
    end

    instr_pack u_pack (
        .fields (s1_fields),
        .instr  (packed_word)
    );

    // S2: hold the packed word. Reset is asynchronous so valid_o drops the
    // moment rst_n_i falls.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
        end else if (en2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_instr <= packed_word;
            end
        end
    end

    assign valid_o = s2_valid;
    assign instr_o = s2_instr;

`ifdef IMM_RANGE_CHECK_EN
    logic               range_err;
    logic               s1_err;
    logic               s2_err;
    logic [7:0]         err_cnt;
    logic signed [31:0] imm_s;

    assign imm_s = $signed(imm_i);

    // Range check on the raw input so the result travels with the beat.
    // B and J offsets must also be even since bit 0 is not encoded.
    always_comb begin
        range_err = 1'b0;
        case (imm_sel_i)
            IMM_I_TYPE,
            IMM_S_TYPE: range_err = (imm_s < IMM12_MIN) || (imm_s > IMM12_MAX);
            IMM_B_TYPE: range_err = (imm_s < IMM13_MIN) || (imm_s > IMM13_MAX)
                                    || imm_i[0];
            IMM_J_TYPE: range_err = (imm_s < IMM21_MIN) || (imm_s > IMM21_MAX)
                                    || imm_i[0];
            IMM_U_TYPE: range_err = |imm_i[11:0];
            default:    range_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_err <= 1'b0;
        end else if (en1 && valid_i) begin
            s1_err <= range_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_err <= 1'b0;
        end else if (en2 && s1_valid) begin
            s2_err <= s1_err;
        end
    end

    // Count error beats only when they actually leave (output handshake),
    // saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_cnt <= '0;
        end else if (s2_valid && ready_i && s2_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_o     = s2_err;
    assign err_cnt_o = err_cnt;
`else
    assign err_o     = 1'b0;
    assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
// Self-checking bench for instr_encoder. A queue-based reference model
// predicts every emitted word from the encoding rules; emitted immediates are
// also decoded back through a sign-extender model and compared with the
// original for in-range values. Directed beats pin the model with literals.
// ---------------------------------------------------------------------------
module tb_instr_encoder;
    import risc_v_32_i_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic        in_range;
        imm_select_e sel;
        logic [31:0] imm;
    } exp_t;

`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    imm_select_e imm_sel_i = IMM_I_TYPE;
    logic [6:0]  opcode_i = '0;
    logic [4:0]  rd_i = '0;
    logic [4:0]  rs1_i = '0;
    logic [4:0]  rs2_i = '0;
    logic [2:0]  funct3_i = '0;
    logic [6:0]  funct7_i = '0;
    logic [31:0] imm_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] instr_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int   n_checks = 0;
    int   n_errors = 0;
    int   model_cnt = 0;
    exp_t q[$];

    always #5 clk_i = ~clk_i;

    instr_encoder #(.XLEN(32)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .imm_sel_i (imm_sel_i),
        .opcode_i  (opcode_i),
        .rd_i      (rd_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .funct3_i  (funct3_i),
        .funct7_i  (funct7_i),
        .imm_i     (imm_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .instr_o   (instr_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Encoding model written as shift-and-mask arithmetic on the immediate.
    function automatic logic [31:0] modelEncode(imm_select_e sel, bit [31:0] opc,
            bit [31:0] rd, bit [31:0] rs1, bit [31:0] rs2, bit [31:0] f3,
            bit [31:0] f7, bit [31:0] imm);
        bit [31:0] regs_i;
        bit [31:0] regs_s;
        regs_i = (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
        regs_s = (rs2 << 20) | (rs1 << 15) | (f3 << 12) | opc;
        case (sel)
            IMM_I_TYPE: return ((imm & 32'hFFF) << 20) | regs_i;
            IMM_S_TYPE: return (((imm >> 5) & 32'h7F) << 25) | regs_s
                               | ((imm & 32'h1F) << 7);
            IMM_B_TYPE: return (((imm >> 12) & 32'h1) << 31)
                               | (((imm >> 5) & 32'h3F) << 25) | regs_s
                               | (((imm >> 1) & 32'hF) << 8)
                               | (((imm >> 11) & 32'h1) << 7);
            IMM_U_TYPE: return (imm & 32'hFFFFF000) | (rd << 7) | opc;
            IMM_J_TYPE: return (((imm >> 20) & 32'h1) << 31)
                               | (((imm >> 1) & 32'h3FF) << 21)
                               | (((imm >> 11) & 32'h1) << 20)
                               | (((imm >> 12) & 32'hFF) << 12)
                               | (rd << 7) | opc;
            default:    return (f7 << 25) | (rs2 << 20) | regs_i;
        endcase
    endfunction

    function automatic bit modelInRange(imm_select_e sel, logic [31:0] imm);
        int v;
        v = signed'(imm);
        case (sel)
            IMM_I_TYPE, IMM_S_TYPE: return (v >= -2048) && (v <= 2047);
            IMM_B_TYPE: return (v >= -4096) && (v <= 4094) && (imm[0] == 1'b0);
            IMM_J_TYPE: return (v >= -1048576) && (v <= 1048574) && (imm[0] == 1'b0);
            IMM_U_TYPE: return (imm & 32'hFFF) == 0;
            default:    return 1'b1;
        endcase
    endfunction

    // The core's immediate sign extender.
    function automatic logic [31:0] extractImm(imm_select_e sel, logic [31:0] i);
        case (sel)
            IMM_I_TYPE: return {{20{i[31]}}, i[31:20]};
            IMM_S_TYPE: return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B_TYPE: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U_TYPE: return {i[31:12], 12'b0};
            IMM_J_TYPE: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:    return 32'h0;
        endcase
    endfunction

    // Compare process: inputs change just after posedge, so negedge values
    // are exactly what the next rising edge will see.
    always @(negedge clk_i) begin
        exp_t e;
        if (!rst_n_i) begin
            q.delete();
            model_cnt = 0;
        end else begin
            checkOutput("err_cnt", {24'h0, err_cnt_o}, model_cnt);
            checkOutput("ready_o", {31'h0, ready_o},
                        {31'h0, (q.size() < 2) || ready_i});
            if (valid_o) begin
                if (q.size() == 0) begin
                    checkOutput("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = q[0];
                    checkOutput("instr", instr_o, e.instr);
                    checkOutput("err", {31'h0, err_o}, {31'h0, e.err});
                    if (e.in_range && e.sel != IMM_UNKNOWN_TYPE)
                        checkOutput("roundtrip", extractImm(e.sel, instr_o), e.imm);
                    if (ready_i) begin
                        void'(q.pop_front());
                        if (e.err && model_cnt < 255) model_cnt++;
                    end
                end
            end
            if (valid_i && ready_o) begin
                e.instr    = modelEncode(imm_sel_i, opcode_i, rd_i, rs1_i, rs2_i,
                                         funct3_i, funct7_i, imm_i);
                e.in_range = modelInRange(imm_sel_i, imm_i);
                e.err      = CHECK_EN && !e.in_range;
                e.sel      = imm_sel_i;
                e.imm      = imm_i;
                q.push_back(e);
            end
        end
    end

    task automatic driveFields(input imm_select_e sel, input logic [6:0] opc,
            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        imm_sel_i = sel;
        opcode_i  = opc;
        rd_i      = rd;
        rs1_i     = rs1;
        rs2_i     = rs2;
        funct3_i  = f3;
        funct7_i  = f7;
        imm_i     = imm;
        valid_i   = 1'b1;
    endtask

    // Offer one beat and return just after the edge that accepts it.
    task automatic applyStimulus(input imm_select_e sel, input logic [6:0] opc,
            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
        int n;
        n = 0;
        driveFields(sel, opc, rd, rs1, rs2, f3, f7, imm);
        while (!ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 50) checkOutput("accept_timeout", 32'd1, 32'd0);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    // Latency: accepted beat sits in S1 first, then appears on the output.
    task automatic runDirected(input string name, input imm_select_e sel,
            input logic [6:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
            input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
            input logic [31:0] exp_instr, input logic exp_err);
        ready_i = 1'b1;
        applyStimulus(sel, opc, rd, rs1, rs2, f3, 7'h0, imm);
        checkOutput({name, "_s1only"}, {31'h0, valid_o}, 32'd0);
        @(posedge clk_i); #1;
        checkOutput({name, "_valid"}, {31'h0, valid_o}, 32'd1);
        checkOutput({name, "_instr"}, instr_o, exp_instr);
        checkOutput({name, "_err"}, {31'h0, err_o}, {31'h0, exp_err});
    endtask

    function automatic logic [31:0] randomImm(imm_select_e sel);
        if ($urandom_range(0, 3) == 0) return $urandom;
        case (sel)
            IMM_I_TYPE, IMM_S_TYPE: return 32'($urandom_range(0, 4095)) - 32'd2048;
            IMM_B_TYPE: return (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            IMM_J_TYPE: return (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
            IMM_U_TYPE: return $urandom & 32'hFFFFF000;
            default:    return $urandom;
        endcase
    endfunction

    initial begin
        imm_select_e rsel;

        // Reset state
        #12;
        checkOutput("rst_valid", {31'h0, valid_o}, 32'd0);
        checkOutput("rst_instr", instr_o, 32'd0);
        checkOutput("rst_err", {31'h0, err_o}, 32'd0);
        checkOutput("rst_cnt", {24'h0, err_cnt_o}, 32'd0);
        checkOutput("rst_ready", {31'h0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Literal encodings
        runDirected("addi", IMM_I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0,
                    32'hFFFFFFFF, 32'hFFF10093, 1'b0);
        runDirected("sw", IMM_S_TYPE, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2,
                    32'd8, 32'h00512423, 1'b0);
        runDirected("jal", IMM_J_TYPE, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0,
                    32'h800, 32'h001000EF, 1'b0);

        // Out-of-range I immediate: truncated word, flagged only with checking
        runDirected("imm2048", IMM_I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0,
                    32'd2048, 32'h80010093, CHECK_EN);
        @(posedge clk_i); #1;
        checkOutput("imm2048_cnt", {24'h0, err_cnt_o}, CHECK_EN ? 32'd1 : 32'd0);

        // Backpressure: three beats offered with ready_i low
        ready_i = 1'b0;
        driveFields(IMM_I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h0, 32'hFFFFFFFF);
        checkOutput("bp_ready_a", {31'h0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        driveFields(IMM_S_TYPE, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'h0, 32'd8);
        checkOutput("bp_ready_b", {31'h0, ready_o}, 32'd1);
        @(posedge clk_i); #1;
        driveFields(IMM_J_TYPE, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h0, 32'h800);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_full", {31'h0, ready_o}, 32'd0);
            checkOutput("bp_hold", instr_o, 32'hFFF10093);
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        checkOutput("bp_out_b", instr_o, 32'h00512423);
        @(posedge clk_i); #1;
        checkOutput("bp_out_c", instr_o, 32'h001000EF);
        checkOutput("bp_out_c_valid", {31'h0, valid_o}, 32'd1);
        @(posedge clk_i); #1;
        checkOutput("bp_empty", {31'h0, valid_o}, 32'd0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 800; i++) begin
            rsel = imm_select_e'(3'($urandom_range(0, 5)));
            driveFields(rsel, 7'($urandom), 5'($urandom), 5'($urandom),
                        5'($urandom), 3'($urandom), 7'($urandom), randomImm(rsel));
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;

        // Saturation of the error counter
        driveFields(IMM_I_TYPE, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h0, 32'd2048);
        repeat (300) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("sat_cnt", {24'h0, err_cnt_o}, CHECK_EN ? 32'd255 : 32'd0);

        // Asynchronous reset with both stages full
        ready_i = 1'b0;
        driveFields(IMM_U_TYPE, 7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'h0, 32'h12345000);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        checkOutput("pre_rst_valid", {31'h0, valid_o}, 32'd1);
        checkOutput("pre_rst_ready", {31'h0, ready_o}, 32'd0);
        #1;
        rst_n_i = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'h0, valid_o}, 32'd0);
        checkOutput("async_rst_cnt", {24'h0, err_cnt_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        #1;
        checkOutput("post_rst_ready", {31'h0, ready_o}, 32'd1);
        ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checkOutput("post_rst_valid", {31'h0, valid_o}, 32'd0);
        checkOutput("drain", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
